// File: rtl/int2float_if.sv
// Handshake and result bundle for int2float_pipe: integer in, packed float fields out.
interface int2float_if #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned MAN_W = 4
);
  localparam int unsigned EXP_W = $clog2(IN_W + 2);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_rnd;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic             out_inexact;

  modport master (
    output in_valid, in_data, in_rnd, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_rnd, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_man, out_inexact
  );
endinterface

// File: rtl/int2float_pipe.sv
// Three-stage integer-to-float converter: magnitude, normalise, round/pack.
// Each stage carries its own valid bit with a ready chain for backpressure.
module int2float_pipe #(
  parameter int unsigned IN_W   = 11,
  parameter int unsigned MAN_W  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  int2float_if.slave bus
);
  localparam int unsigned EXP_W = $clog2(IN_W + 2);
  localparam int unsigned PW    = $clog2(IN_W);
  localparam int unsigned RW    = IN_W - MAN_W;
  localparam logic [PW-1:0] PMAX = PW'(IN_W - 1);

  logic v1_q, v2_q, v3_q;
  logic rdy1, rdy2, rdy3;

  // Stage 1: sign and magnitude
  logic            sign1_q, rnd1_q;
  logic [IN_W-1:0] mag1_q;
  logic            neg_d;
  logic [IN_W-1:0] mag_d;

  // Stage 2: leading-one position and fraction below the leading one
  logic            sign2_q, rnd2_q, zero2_q;
  logic [PW-1:0]   p2_q;
  logic [IN_W-2:0] frac2_q;
  logic [PW-1:0]   p_d;
  logic [IN_W-1:0] shifted;

  // Stage 3: packed result registers
  logic             sign3_q, inx3_q;
  logic [EXP_W-1:0] exp3_q;
  logic [MAN_W-1:0] man3_q;

  logic [IN_W-1:0]  ext;
  logic [MAN_W-1:0] man_t;
  logic [RW-1:0]    rem, rem_sh;
  logic             round_up;
  logic [MAN_W:0]   man_up;
  logic [EXP_W-1:0] exp_d;

  assign rdy3         = !v3_q || bus.out_ready;
  assign rdy2         = !v2_q || rdy3;
  assign rdy1         = !v1_q || rdy2;
  assign bus.in_ready = rdy1;

  // Two's complement negate keeps the most negative value exact as unsigned.
  always_comb begin
    neg_d = 1'b0;
    mag_d = bus.in_data;
    if (SIGNED) begin
      neg_d = bus.in_data[IN_W-1];
      if (neg_d) mag_d = ~bus.in_data + {{(IN_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    p_d = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag1_q[i]) p_d = PW'(i);
    end
    shifted = mag1_q << (PMAX - p_d);
  end

  // A zero pad bit below the fraction keeps the remainder non-empty when MAN_W = IN_W-1.
  always_comb begin
    ext      = {frac2_q, 1'b0};
    man_t    = ext[IN_W-1 -: MAN_W];
    rem      = ext[RW-1:0];
    rem_sh   = rem << 1;
    round_up = rnd2_q && rem[RW-1] && ((|rem_sh) || man_t[0]);
    man_up   = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    exp_d    = '0;
    if (!zero2_q) exp_d = EXP_W'(p2_q) + EXP_W'(1) + EXP_W'(man_up[MAN_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sign1_q <= 1'b0;
      rnd1_q  <= 1'b0;
      mag1_q  <= '0;
      sign2_q <= 1'b0;
      rnd2_q  <= 1'b0;
      zero2_q <= 1'b0;
      p2_q    <= '0;
      frac2_q <= '0;
      sign3_q <= 1'b0;
      inx3_q  <= 1'b0;
      exp3_q  <= '0;
      man3_q  <= '0;
    end else begin
      if (rdy1) v1_q <= bus.in_valid;
      if (bus.in_valid && rdy1) begin
        sign1_q <= neg_d;
        rnd1_q  <= bus.in_rnd;
        mag1_q  <= mag_d;
      end
      if (rdy2) v2_q <= v1_q;
      if (v1_q && rdy2) begin
        sign2_q <= sign1_q;
        rnd2_q  <= rnd1_q;
        zero2_q <= !shifted[IN_W-1];
        p2_q    <= p_d;
        frac2_q <= shifted[IN_W-2:0];
      end
      if (rdy3) v3_q <= v2_q;
      if (v2_q && rdy3) begin
        sign3_q <= sign2_q && !zero2_q;
        inx3_q  <= |rem;
        exp3_q  <= exp_d;
        man3_q  <= man_up[MAN_W-1:0];
      end
    end
  end

  assign bus.out_valid   = v3_q;
  assign bus.out_sign    = sign3_q;
  assign bus.out_exp     = exp3_q;
  assign bus.out_man     = man3_q;
  assign bus.out_inexact = inx3_q;
endmodule
